ladder_lap_monitor: RTL and testbench
=====================================

Name: ladder_lap_monitor

Overview:
- Downstream consumer of the delta ladder counter. Samples its count/delta pair every enabled cycle and detects wrap-arounds (laps).
- Checks every step against the expected increment and keeps a lap total against a programmable limit.
- Queues one lap event per wrap in a small FIFO, drained through a valid/ready handshake to the reporting logic.

Parameters:
- CNT_W, 4, width of sampled count
- DELTA_W, 3, width of sampled delta; must satisfy 2^DELTA_W <= 2^CNT_W, so at most one wrap per step
- LAP_W, 8, width of lap counter and lap limit
- FIFO_DEPTH, 4, event FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous reset, active-high despite the name; 1 = reset
- en  in  1  count/delta sample is valid this cycle
- count  in  CNT_W  counter value after this step
- delta  in  DELTA_W  increment that produced count
- lap_limit  in  LAP_W  lap total that ends tracking; 0 = unlimited
- clear  in  1  synchronous restart to IDLE; empties FIFO, zeroes counters
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_lap  out  LAP_W  lap index of head event (1-based)
- evt_residue  out  CNT_W  count value right after the wrap
- lap_count  out  LAP_W  laps seen so far
- done  out  1  lap_limit reached
- step_err  out  1  sticky: count != prev+delta mod 2^CNT_W
- drop_cnt  out  4  saturating count of events lost to a full FIFO

Behaviour:
- Reset (async assert, sync release): state=IDLE; prev_count=0; lap_count=0; done=0; step_err=0; drop_cnt=0; FIFO empty; evt_valid=0; evt_lap=0; evt_residue=0.
- FSM states:
  - IDLE: first en cycle captures prev_count=count, moves to TRACK. No check, no lap.
  - TRACK: on each en cycle:
    - wrap = (count < prev_count), unsigned compare.
    - Expected value = (prev_count+delta) mod 2^CNT_W. If count differs, set step_err (sticky until reset/clear). Wrap is still judged from the compare.
    - prev_count <= count.
    - On wrap: lap_count <= lap_count+1 and push {lap_count+1, count}.
    - If lap_limit != 0 and lap_count+1 == lap_limit: go to DONE, done=1 from the next cycle.
  - DONE: samples ignored, lap_count frozen, FIFO still drains. Only clear or reset leaves DONE.
- delta=0 or a repeated count: no wrap, no check failure when count == prev_count.
- lap_count wraps modulo 2^LAP_W when lap_limit=0.
- clear: takes priority over en in the same cycle. Next cycle: state=IDLE, counters zero, step_err=0, drop_cnt=0, FIFO empty, evt_valid=0. Any push in that cycle is discarded.
- FIFO:
  - Registered; push at the detection edge, so evt_valid rises 1 cycle after the wrapping sample (latency 1).
  - evt_lap/evt_residue stay stable while evt_valid=1 and evt_ready=0.
  - Pop when evt_valid && evt_ready.
  - Full and push with no pop: event dropped, drop_cnt+1, saturating at 15.
  - Full with push and pop in the same cycle: both happen, no drop, occupancy unchanged.
  - Empty with push and evt_ready=1: no bypass; the event appears next cycle.
- Reset mid-operation: all state clears immediately, in-flight events are lost, evt_valid drops asynchronously.

Test Plan:
- Reset, en=1, delta=3, count sequence 0,3,6,9,12,15,2,5 -> one event; evt_valid rises the cycle after count=2, evt_lap=1, evt_residue=2; lap_count=1; step_err=0.
- lap_limit=2, delta=7 from 0: 0,7,14,5,12,3,10 -> events (1,5) and (2,3); done=1 the cycle after count=3; the later sample 10 is ignored; lap_count holds 2.
- delta=2 with count jumping 4->9 -> step_err=1 and stays 1 through later correct steps until clear; no lap counted.
- evt_ready=0, delta=7, lap_limit=0, force 6 wraps -> 4 queued, drop_cnt=2. Then evt_ready=1 -> laps 1,2,3,4 drain in order, one per cycle. Repeat with full FIFO plus simultaneous push/pop -> no drop.
- Assert resetn for 5 ns mid-stream with 2 events queued -> evt_valid=0 and all counters 0 immediately. After release, the first en sample only primes prev_count (no event even if its value is lower than the pre-reset count).
- clear asserted in the same cycle as a wrapping sample -> no event, lap_count=0, state IDLE next cycle.

Source files
------------

// File: rtl/ladder_lap_monitor_if.sv
// Lap event stream between the lap monitor and the reporting logic.
// The producer owns valid and payload; the consumer owns ready.
interface ladder_lap_monitor_if #(
    parameter int CNT_W = 4,
    parameter int LAP_W = 8
);
    logic             evt_valid;
    logic             evt_ready;
    logic [LAP_W-1:0] evt_lap;
    logic [CNT_W-1:0] evt_residue;

    modport master (
        output evt_valid,
        output evt_lap,
        output evt_residue,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_lap,
        input  evt_residue,
        output evt_ready
    );
endinterface

// File: rtl/ladder_lap_monitor.sv
// Watches a delta ladder counter, flags bad steps, counts wrap-arounds and
// queues one lap event per wrap into a small first-word-fall-through FIFO.
module ladder_lap_monitor #(
    parameter int CNT_W      = 4,
    parameter int DELTA_W    = 3,
    parameter int LAP_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic [CNT_W-1:0]     count,
    input  logic [DELTA_W-1:0]   delta,
    input  logic [LAP_W-1:0]     lap_limit,
    input  logic                 clear,
    ladder_lap_monitor_if.master evt,
    output logic [LAP_W-1:0]     lap_count,
    output logic                 done,
    output logic                 step_err,
    output logic [3:0]           drop_cnt
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W   = PTR_W + 1;
    localparam int ENTRY_W = LAP_W + CNT_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   prev_reg;
    logic [LAP_W-1:0]   lap_reg;
    logic               err_reg;
    logic [3:0]         drop_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [OCC_W-1:0]   occ_reg;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0] head;

    logic               capture;
    logic               check;
    logic               wrap;
    logic               limit_hit;
    logic [CNT_W-1:0]   expected;
    logic [LAP_W-1:0]   lap_inc;
    logic               push_req;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               push_ok;
    logic               drop;

    // Step arithmetic; at most one wrap per step, so an unsigned compare suffices.
    assign wrap      = (count < prev_reg);
    assign expected  = prev_reg + CNT_W'(delta);
    assign lap_inc   = lap_reg + LAP_W'(1);
    assign limit_hit = (lap_limit != '0) && (lap_inc == lap_limit);

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        check      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (en) begin
                    capture    = 1'b1;
                    state_next = S_TRACK;
                end
            end
            S_TRACK: begin
                if (en) begin
                    capture = 1'b1;
                    check   = 1'b1;
                    if (wrap && limit_hit) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // A restart overrides whatever the sample would have done.
        if (clear) begin
            state_next = S_IDLE;
            capture    = 1'b0;
            check      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign fifo_empty = (occ_reg == '0);
    assign fifo_full  = (occ_reg == OCC_W'(FIFO_DEPTH));
    assign push_req   = check && wrap;
    assign pop        = !fifo_empty && evt.evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            prev_reg   <= '0;
            lap_reg    <= '0;
            err_reg    <= 1'b0;
            drop_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else if (clear) begin
            prev_reg   <= '0;
            lap_reg    <= '0;
            err_reg    <= 1'b0;
            drop_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (capture) begin
                prev_reg <= count;
            end
            if (check && (count != expected)) begin
                err_reg <= 1'b1;
            end
            if (push_req) begin
                lap_reg <= lap_inc;
            end
            if (drop && (drop_reg != 4'hF)) begin
                drop_reg <= drop_reg + 4'd1;
            end
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   occ_reg <= occ_reg + OCC_W'(1);
                2'b01:   occ_reg <= occ_reg - OCC_W'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= {lap_inc, count};
        end
    end

    assign head            = mem[rd_ptr_reg];
    assign evt.evt_valid   = !fifo_empty;
    assign evt.evt_lap     = fifo_empty ? '0 : head[ENTRY_W-1:CNT_W];
    assign evt.evt_residue = fifo_empty ? '0 : head[CNT_W-1:0];

    assign lap_count = lap_reg;
    assign done      = (state_reg == S_DONE);
    assign step_err  = err_reg;
    assign drop_cnt  = drop_reg;

endmodule

// File: tb/tb_ladder_lap_monitor.sv
// Bench for ladder_lap_monitor: table vectors, directed corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_ladder_lap_monitor;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       en = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] count = '0;
    logic [2:0] delta = '0;
    logic [7:0] lap_limit = '0;
    logic [7:0] lap_count;
    logic       done;
    logic       step_err;
    logic [3:0] drop_cnt;

    ladder_lap_monitor_if #(.CNT_W(4), .LAP_W(8)) evt_if ();

    ladder_lap_monitor #(
        .CNT_W(4), .DELTA_W(3), .LAP_W(8), .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .count     (count),
        .delta     (delta),
        .lap_limit (lap_limit),
        .clear     (clear),
        .evt       (evt_if),
        .lap_count (lap_count),
        .done      (done),
        .step_err  (step_err),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int lim   = 0;

    // Reference model: tracking flag, lap total and an event queue.
    typedef struct { int lap; int res; } ev_t;
    ev_t q[$];
    bit  m_started;
    bit  m_finished;
    int  m_prev;
    int  m_laps;
    bit  m_err;
    int  m_drops;

    task automatic model_reset();
        q.delete();
        m_started = 0; m_finished = 0; m_prev = 0;
        m_laps = 0; m_err = 0; m_drops = 0;
    endtask

    task automatic model_step(input bit e, input int c, input int d, input bit clr,
                              input bit r, input int lm);
        bit  pop;
        bit  push;
        ev_t ev;
        pop  = (q.size() > 0) && r;
        push = 0;
        ev   = '{0, 0};
        if (clr) begin
            model_reset();
            return;
        end
        if (e && !m_started) begin
            m_started = 1;
            m_prev = c;
        end else if (e && !m_finished) begin
            if (c != (m_prev + d) % 16) m_err = 1;
            if (c < m_prev) begin
                m_laps = (m_laps + 1) % 256;
                ev = '{m_laps, c};
                push = 1;
                if (lm != 0 && m_laps == lm) m_finished = 1;
            end
            m_prev = c;
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < 4) q.push_back(ev);
            else if (m_drops < 15) m_drops++;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("valid", int'(evt_if.evt_valid), (q.size() > 0) ? 1 : 0);
        chk("evt_lap", int'(evt_if.evt_lap), (q.size() > 0) ? q[0].lap : 0);
        chk("evt_residue", int'(evt_if.evt_residue), (q.size() > 0) ? q[0].res : 0);
        chk("lap_count", int'(lap_count), m_laps);
        chk("done", int'(done), m_finished ? 1 : 0);
        chk("step_err", int'(step_err), m_err ? 1 : 0);
        chk("drop_cnt", int'(drop_cnt), m_drops);
    endtask

    // One clock: drive at edge+1, advance the model, compare at the next edge+1.
    task automatic cyc(input bit e, input int c, input int d, input bit clr, input bit r);
        int cv;
        int dv;
        int lv;
        cv = c; dv = d; lv = lim;
        en = e;
        count = cv[3:0];
        delta = dv[2:0];
        clear = clr;
        evt_if.evt_ready = r;
        lap_limit = lv[7:0];
        model_step(e, c, d, clr, r, lim);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        en = 0; clear = 0; evt_if.evt_ready = 0;
        resetn = 1;
        model_reset();
        @(posedge clk);
        #4;
        resetn = 0;
        @(posedge clk);
        #1;
        compare_model();
    endtask

    typedef struct {
        bit rst_before; int lm; bit e; int c; int d; bit r;
        int x_valid; int x_lap; int x_res; int x_laps; int x_done; int x_err;
    } vec_t;
    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s4[15];
        int s4b[9];
        int drv;

        evt_if.evt_ready = 0;

        // Single wrap with delta 3, then a two-lap limit with delta 7 and drain.
        tbl.push_back('{1, 0, 1, 0,  3, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 3,  3, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 6,  3, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 9,  3, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 12, 3, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 15, 3, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 2,  3, 0, 1, 1, 2, 1, 0, 0});
        tbl.push_back('{0, 0, 1, 5,  3, 0, 1, 1, 2, 1, 0, 0});
        tbl.push_back('{1, 2, 1, 0,  7, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 2, 1, 7,  7, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 2, 1, 14, 7, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 2, 1, 5,  7, 0, 1, 1, 5, 1, 0, 0});
        tbl.push_back('{0, 2, 1, 12, 7, 0, 1, 1, 5, 1, 0, 0});
        tbl.push_back('{0, 2, 1, 3,  7, 0, 1, 1, 5, 2, 1, 0});
        tbl.push_back('{0, 2, 1, 10, 7, 0, 1, 1, 5, 2, 1, 0});
        tbl.push_back('{0, 2, 0, 0,  7, 1, 1, 2, 3, 2, 1, 0});
        tbl.push_back('{0, 2, 0, 0,  7, 1, 0, 0, 0, 2, 1, 0});

        lim = 0;
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_before) begin
                lim = tbl[i].lm;
                do_reset();
            end
            lim = tbl[i].lm;
            cyc(tbl[i].e, tbl[i].c, tbl[i].d, 1'b0, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), int'(evt_if.evt_valid), tbl[i].x_valid);
            chk($sformatf("tbl%0d_lap", i), int'(evt_if.evt_lap), tbl[i].x_lap);
            chk($sformatf("tbl%0d_res", i), int'(evt_if.evt_residue), tbl[i].x_res);
            chk($sformatf("tbl%0d_laps", i), int'(lap_count), tbl[i].x_laps);
            chk($sformatf("tbl%0d_done", i), int'(done), tbl[i].x_done);
            chk($sformatf("tbl%0d_err", i), int'(step_err), tbl[i].x_err);
        end

        // Bad step is sticky across good steps and cleared only by clear.
        lim = 0;
        do_reset();
        cyc(1, 0, 2, 0, 1); cyc(1, 2, 2, 0, 1); cyc(1, 4, 2, 0, 1);
        cyc(1, 9, 2, 0, 1);
        chk("err_set", int'(step_err), 1);
        cyc(1, 11, 2, 0, 1); cyc(1, 13, 2, 0, 1);
        chk("err_sticky", int'(step_err), 1);
        chk("err_nolap", int'(lap_count), 0);
        cyc(0, 0, 2, 1, 1);
        chk("err_cleared", int'(step_err), 0);

        // Six wraps into a stalled FIFO: four kept, two dropped, drain in order.
        s4 = '{0, 7, 14, 5, 12, 3, 10, 1, 8, 15, 6, 13, 4, 11, 2};
        do_reset();
        foreach (s4[k]) cyc(1, s4[k], 7, 0, 0);
        chk("full_drop", int'(drop_cnt), 2);
        chk("full_head", int'(evt_if.evt_lap), 1);
        for (int k = 1; k <= 4; k++) begin
            cyc(0, 0, 7, 0, 1);
            if (k < 4) chk($sformatf("drain%0d_lap", k), int'(evt_if.evt_lap), k + 1);
            else chk("drain_empty", int'(evt_if.evt_valid), 0);
        end
        // Refill to full, then push and pop together: nothing lost.
        s4b = '{9, 0, 7, 14, 5, 12, 3, 10, 1};
        foreach (s4b[k]) cyc(1, s4b[k], 7, 0, 0);
        cyc(1, 8, 7, 0, 0); cyc(1, 15, 7, 0, 0);
        cyc(1, 6, 7, 0, 1);
        chk("pushpop_drop", int'(drop_cnt), 2);
        chk("pushpop_head", int'(evt_if.evt_lap), 8);
        chk("pushpop_valid", int'(evt_if.evt_valid), 1);

        // Asynchronous reset mid-stream with two events queued.
        do_reset();
        cyc(1, 0, 7, 0, 0); cyc(1, 7, 7, 0, 0); cyc(1, 14, 7, 0, 0);
        cyc(1, 5, 7, 0, 0); cyc(1, 12, 7, 0, 0); cyc(1, 3, 7, 0, 0);
        cyc(1, 10, 7, 0, 0);
        chk("pre_rst_valid", int'(evt_if.evt_valid), 1);
        resetn = 1;
        #1;
        chk("async_valid", int'(evt_if.evt_valid), 0);
        chk("async_laps", int'(lap_count), 0);
        chk("async_err", int'(step_err), 0);
        #4;
        resetn = 0;
        model_reset();
        cyc(1, 2, 7, 0, 0);
        chk("prime_novalid", int'(evt_if.evt_valid), 0);
        cyc(1, 9, 7, 0, 0);
        chk("prime_laps", int'(lap_count), 0);

        // Clear coinciding with a wrapping sample discards the event.
        do_reset();
        cyc(1, 0, 7, 0, 0); cyc(1, 7, 7, 0, 0); cyc(1, 14, 7, 0, 0);
        cyc(1, 5, 7, 1, 0);
        chk("clr_valid", int'(evt_if.evt_valid), 0);
        chk("clr_laps", int'(lap_count), 0);
        cyc(1, 3, 7, 0, 0);
        chk("clr_idle", int'(evt_if.evt_valid), 0);

        // Randomized traffic against the model.
        do_reset();
        drv = 0;
        for (int n = 0; n < 600; n++) begin
            int  e;
            int  d;
            int  c;
            bit  clr;
            bit  r;
            if (n % 150 == 0) begin
                case ((n / 150) % 4)
                    0: lim = 0;
                    1: lim = 3;
                    2: lim = 5;
                    default: lim = 0;
                endcase
            end
            e   = ($urandom % 4) != 0;
            d   = $urandom % 8;
            c   = (($urandom % 12) == 0) ? int'($urandom % 16) : (drv + d) % 16;
            clr = ($urandom % 60) == 0;
            r   = ($urandom % 3) != 0;
            if (e) drv = c;
            cyc(e[0], c, d, clr, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
